prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream boot stage of the accumulator CPU.
- Receives a framed program image over a byte-wide valid/ready stream and writes it into the 32x8 program/data memory through the memory write port.
- Asserts cpu_run only after a complete frame passes its length and checksum checks. The CPU is held idle until cpu_run is high.
- Frame format: length byte N (1..32), then N data bytes for addresses 0..N-1, then a checksum byte. A frame is good when the sum of all N+2 bytes, mod 256, is 0.

Parameters:
- ADDR_W, 5, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, byte/memory word width.
- TIMEOUT, 255, consecutive stalled cycles allowed inside a frame before abort (range 1..2**16-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a new load.
- s_valid  in  1  stream byte valid.
- s_data  in  DATA_W  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_din  out  DATA_W  memory write data.
- busy  out  1  frame in progress.
- cpu_run  out  1  program loaded and valid; CPU may execute.
- err  out  1  last frame aborted.
- err_code  out  2  0 none, 1 bad length, 2 bad checksum, 3 timeout.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Internal sum, index and timeout counter cleared. Reset taken mid-frame discards the partial frame. Memory contents already written are not touched.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- Handshake: a byte transfers on a rising edge where s_valid=1 and s_ready=1.
  - s_ready=1 only in LEN, DATA and CSUM, and is a registered output (not a combinational function of s_valid).
  - s_data is ignored in all other states.
- busy=1 in LEN, DATA and CSUM.
- start:
  - Honoured in IDLE, DONE and ERR: next state LEN; cpu_run, err and err_code clear on that edge.
  - Ignored in LEN, DATA and CSUM.
- LEN state, on handshake:
  - N=0 or N>2**ADDR_W: go to ERR with err_code=1.
  - Otherwise: store N, sum=N, index=0, go to DATA.
- DATA state, on handshake:
  - sum+=byte (mod 256).
  - Byte is captured into the registered write port: the next cycle has mem_wr=1, mem_addr=index, mem_din=byte. Write latency is exactly 1 cycle.
  - index increments. When index reaches N-1 at the handshake, go to CSUM.
  - Back-to-back handshakes produce back-to-back writes.
- CSUM state, on handshake:
  - If (sum+byte) mod 256 == 0: go to DONE.
  - Otherwise: go to ERR with err_code=2.
- DONE: cpu_run=1, held until the next start or reset.
- ERR: err=1 and err_code held; cpu_run=0; s_ready=0.
- mem_wr is 1 for exactly one cycle per data byte and never for the length or checksum byte.
  - The last data write's mem_wr pulse coincides with the CSUM state's first cycle.
- Timeout:
  - Counter clears on every handshake and on entry to LEN.
  - It increments on each LEN/DATA/CSUM cycle without a handshake.
  - The edge ending the TIMEOUT-th consecutive stalled cycle moves the FSM to ERR with err_code=3.
  - If a handshake and the timeout limit fall in the same cycle, the handshake wins.
- Arithmetic: sum and index wrap naturally at their widths. index never exceeds N-1 by construction.
- Indices are one unsigned ADDR_W+1 bit so N=32 is representable.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W constants, shared with memory and PC.
  - Typedef ldr_state_t {IDLE, LEN, DATA, CSUM, DONE, ERR}.
  - Typedef ldr_err_t {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TMO}.
- One natural sub-module: ldr_timeout. Inputs: clk, rst, clear, count_en. Output: expired. Parameterised by TIMEOUT.

Test Plan:
- Good 3-byte frame: start, then bytes 03,21,42,84,16 with continuous valid. Required: writes mem[0]=21, mem[1]=42, mem[2]=84 on consecutive cycles, then cpu_run=1, err=0.
- Bad checksum: frame 03,21,42,84,17. Required: the same three writes occur, then err=1, err_code=2, cpu_run=0.
- Bad length, two frames:
  - Frame beginning 00: err_code=1, zero mem_wr pulses.
  - Frame beginning 21 (33): err_code=1, zero mem_wr pulses.
  - In both cases s_ready drops the cycle after the length byte.
- Full depth with backpressure: N=32, bytes 0..31, random valid gaps shorter than TIMEOUT, correct checksum. Required: 32 writes to addresses 0..31, then cpu_run=1.
- Timeout: TIMEOUT=4. Send 02,AA, then hold s_valid=0. Required: ERR with err_code=3 exactly 4 cycles after the last handshake; one write to mem[0]=AA.
- Control corner cases:
  - start pulsed mid-frame: ignored.
  - rst low mid-DATA: all outputs are 0 within the same cycle, state is IDLE, and a following good frame loads correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its boot loader: memory
// geometry plus the loader's state and error encodings.
package cpu_pkg;

    // Program/data memory geometry shared by memory, PC and loader.
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // Loader frame-walk states.
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } ldr_state_t;

    // Reason the last frame was aborted, as seen on err_code.
    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CSUM = 2'd2,
        ERR_TMO  = 2'd3
    } ldr_err_t;

    // States in which a frame is being received and bytes are accepted.
    function automatic logic is_busy(ldr_state_t s);
        return s inside {LEN, DATA, CSUM};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream into the loader plus the loader's memory write port.
// master: the upstream byte source / memory side; slave: the loader.
interface prog_loader_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_wr,
        input  mem_addr,
        input  mem_din
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_wr,
        output mem_addr,
        output mem_din
    );

endinterface

// File: rtl/ldr_timeout.sv
// Stall watchdog for the loader: counts consecutive stalled cycles and flags
// the cycle whose closing edge would be the TIMEOUT-th stall in a row.
module ldr_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int              CNT_W = 16;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over counting; otherwise hold.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            count_q <= count_d;
        end
    end

    // This stalled cycle is the TIMEOUT-th in a row once count_q has seen TIMEOUT-1.
    assign expired = count_en && !clear && (count_q == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length/data/checksum frame on a byte stream, writes
// the data bytes into program memory and releases the CPU only when the whole
// frame checks out.
module prog_loader #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    prog_loader_if.slave bus,
    output logic       busy,
    output logic       cpu_run,
    output logic       err,
    output logic [1:0] err_code
);

    import cpu_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra bit so a full-depth length (DEPTH) is representable.
    localparam int IDX_W = ADDR_W + 1;

    ldr_state_t        state_q,    state_d;
    logic [IDX_W-1:0]  len_q,      len_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DATA_W-1:0] sum_q,      sum_d;
    logic              wr_q,       wr_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    ldr_err_t          err_code_q, err_code_d;
    logic              busy_q,     busy_d;
    logic              run_q,      run_d;
    logic              err_q,      err_d;

    logic              hs;
    logic              len_bad;
    logic [DATA_W-1:0] sum_add;
    logic              tmo_clear;
    logic              tmo_count;
    logic              tmo_expired;

    // s_ready is the registered busy flag, so it never depends on s_valid.
    assign hs        = bus.s_valid & busy_q;
    assign sum_add   = sum_q + bus.s_data;
    assign len_bad   = (bus.s_data == '0) ||
                       ({1'b0, bus.s_data} > (DATA_W + 1)'(DEPTH));
    assign tmo_count = busy_q & ~hs;

    ldr_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmo_clear),
        .count_en (tmo_count),
        .expired  (tmo_expired)
    );

    // Next state, frame bookkeeping, write-port capture and registered outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        wr_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        tmo_clear  = hs;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN;
                    err_code_d = ERR_NONE;
                    tmo_clear  = 1'b1;
                end
            end
            LEN: begin
                if (hs) begin
                    if (len_bad) begin
                        state_d    = ERR;
                        err_code_d = ERR_LEN;
                    end else begin
                        len_d   = bus.s_data[IDX_W-1:0];
                        sum_d   = bus.s_data;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (hs) begin
                    sum_d   = sum_add;
                    wr_d    = 1'b1;
                    waddr_d = idx_q[ADDR_W-1:0];
                    wdata_d = bus.s_data;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == len_q - IDX_W'(1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (hs) begin
                    if (sum_add == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ERR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stall that reaches the limit aborts; a handshake in the same cycle wins.
        if (tmo_expired) begin
            state_d    = ERR;
            err_code_d = ERR_TMO;
        end

        busy_d = is_busy(state_d);
        run_d  = (state_d == DONE);
        err_d  = (state_d == ERR);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath, write port and status output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            run_q      <= run_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_ready  = busy_q;
    assign bus.mem_wr   = wr_q;
    assign bus.mem_addr = waddr_q;
    assign bus.mem_din  = wdata_q;
    assign busy         = busy_q;
    assign cpu_run      = run_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are built from the framing
// rules, outcomes and memory writes are predicted from the byte list alone.
module tb_prog_loader;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;
    localparam int HALF    = 5;
    localparam int DEPTH   = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       cpu_run;
    logic       err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.slave),
        .busy     (busy),
        .cpu_run  (cpu_run),
        .err      (err),
        .err_code (err_code)
    );

    always #HALF clk = ~clk;

    // Observed memory (what the write port did) and model memory (what should be there).
    logic [7:0] tb_mem  [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    int         wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    time        wr_time_q [$];
    logic [7:0] frame_q   [$];

    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wr_addr_q.push_back(int'(bus.mem_addr));
            wr_data_q.push_back(bus.mem_din);
            wr_time_q.push_back($time);
            tb_mem[bus.mem_addr] = bus.mem_din;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0 || cpu_run !== 1'b0 || err !== 1'b0 ||
            err_code !== 2'd0 || bus.mem_wr !== 1'b0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b s_ready=%b cpu_run=%b err=%b err_code=%0d mem_wr=%b addr=%0d din=%h, required all 0",
                     name, busy, bus.s_ready, cpu_run, err, err_code, bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
    endtask

    task automatic do_start(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.s_ready !== 1'b1 || cpu_run !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL %s start: busy=%b s_ready=%b cpu_run=%b err=%b err_code=%0d, required 1 1 0 0 0",
                     name, busy, bus.s_ready, cpu_run, err, err_code);
        end
    endtask

    // Offer one byte after gap idle cycles; returns the time of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse,
                             input string name, output time t_hs);
        bit ok;
        ok   = 1'b0;
        t_hs = 0;
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        if (pulse) start = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (bus.s_ready === 1'b1) begin
                @(posedge clk);
                t_hs = $time;
                @(negedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s handshake: byte %h accepted=0, required accepted=1", name, b);
        end
    endtask

    task automatic make_frame(input int n, input bit bad_csum);
        logic [7:0] s;
        logic [7:0] d;
        frame_q.delete();
        frame_q.push_back(8'(n));
        if (n < 1 || n > DEPTH) return;
        s = 8'(n);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            frame_q.push_back(d);
            s = s + d;
        end
        s = 8'h00 - s;
        if (bad_csum) s = s + 8'($urandom_range(1, 255));
        frame_q.push_back(s);
    endtask

    // Send frame_q and check writes, timing, final status and memory image.
    task automatic run_frame(input string name, input int max_gap, input int pulse_at);
        int         n;
        bit         len_ok;
        bit         good;
        int         exp_code;
        int         exp_wr;
        int         bad_words;
        logic [7:0] s;
        time        t;
        time        hs_t [$];

        wr_addr_q.delete();
        wr_data_q.delete();
        wr_time_q.delete();
        do_start(name);

        n      = int'(frame_q[0]);
        len_ok = (n >= 1) && (n <= DEPTH);
        s      = 8'h00;
        foreach (frame_q[i]) s = s + frame_q[i];
        good     = len_ok && (s == 8'h00);
        exp_code = !len_ok ? 1 : (good ? 0 : 2);
        exp_wr   = len_ok ? n : 0;

        if (!len_ok) begin
            send_byte(frame_q[0], $urandom_range(0, max_gap), 1'b0, name, t);
            checks++;
            if (bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s s_ready after length: %b, required 0", name, bus.s_ready);
            end
        end else begin
            for (int i = 0; i < frame_q.size(); i++) begin
                send_byte(frame_q[i], $urandom_range(0, max_gap), (i == pulse_at), name, t);
                if (i >= 1 && i <= n) hs_t.push_back(t);
            end
        end
        repeat (3) @(negedge clk);

        checks++;
        if (wr_addr_q.size() != exp_wr) begin
            errors++;
            $display("FAIL %s write count: %0d, required %0d", name, wr_addr_q.size(), exp_wr);
        end
        for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== frame_q[i+1] || wr_time_q[i] != hs_t[i] + HALF) begin
                errors++;
                $display("FAIL %s write[%0d]: addr=%0d data=%h t=%0t, required addr=%0d data=%h t=%0t",
                         name, i, wr_addr_q[i], wr_data_q[i], wr_time_q[i], i, frame_q[i+1], hs_t[i] + HALF);
            end
        end
        for (int i = 0; i < exp_wr; i++) exp_mem[i] = frame_q[i+1];

        checks++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0 || cpu_run !== good || err !== !good || err_code !== 2'(exp_code)) begin
            errors++;
            $display("FAIL %s status: busy=%b s_ready=%b cpu_run=%b err=%b err_code=%0d, required 0 0 %b %b %0d",
                     name, busy, bus.s_ready, cpu_run, err, err_code, good, !good, exp_code);
        end

        bad_words = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== exp_mem[i]) bad_words++;
        checks++;
        if (bad_words != 0) begin
            errors++;
            $display("FAIL %s memory image: %0d differing words, required 0", name, bad_words);
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.s_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.s_valid = 1'b0;
        check_idle_outputs("idle_ignores_stream");
    endtask

    task automatic test_good();
        frame_q = '{8'h03, 8'h21, 8'h42, 8'h84, 8'h16};
        run_frame("good3", 0, -1);
        repeat (5) @(negedge clk);
        checks++;
        if (cpu_run !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL good3 run held: cpu_run=%b err=%b, required 1 0", cpu_run, err);
        end
    endtask

    task automatic test_bad_csum();
        frame_q = '{8'h03, 8'h21, 8'h42, 8'h84, 8'h17};
        run_frame("bad_csum", 0, -1);
    endtask

    task automatic test_bad_len();
        frame_q = '{8'h00};
        run_frame("bad_len_0", 0, -1);
        frame_q = '{8'h21};
        run_frame("bad_len_33", 0, -1);
    endtask

    task automatic test_full_depth();
        logic [7:0] s;
        frame_q.delete();
        frame_q.push_back(8'd32);
        s = 8'd32;
        for (int i = 0; i < DEPTH; i++) begin
            frame_q.push_back(8'(i));
            s = s + 8'(i);
        end
        frame_q.push_back(8'h00 - s);
        run_frame("full_depth", TIMEOUT - 1, -1);
    endtask

    task automatic test_timeout();
        time t;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_time_q.delete();
        do_start("timeout");
        send_byte(8'h02, 0, 1'b0, "timeout", t);
        send_byte(8'hAA, 0, 1'b0, "timeout", t);
        for (int k = 0; k <= TIMEOUT; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (k < TIMEOUT) begin
                if (err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout early k=%0d: err=%b busy=%b, required 0 1", k, err, busy);
                end
            end else if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || cpu_run !== 1'b0 || $time != t + TIMEOUT * 2 * HALF + HALF) begin
                errors++;
                $display("FAIL timeout expiry: err=%b err_code=%0d busy=%b cpu_run=%b t=%0t, required 1 3 0 0 t=%0t",
                         err, err_code, busy, cpu_run, $time, t + TIMEOUT * 2 * HALF + HALF);
            end
        end
        exp_mem[0] = 8'hAA;
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] !== 8'hAA) begin
            errors++;
            $display("FAIL timeout writes: count=%0d first=%h, required count=1 mem[0]=aa",
                     wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 8'h00);
        end
    endtask

    task automatic test_timeout_len();
        do_start("timeout_len");
        repeat (TIMEOUT) @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: err=%b err_code=%0d s_ready=%b, required 1 3 0", err, err_code, bus.s_ready);
        end
    endtask

    task automatic test_start_mid_frame();
        make_frame(6, 1'b0);
        run_frame("start_mid", 1, 3);
    endtask

    task automatic test_reset_mid();
        time        t;
        logic [7:0] d0;
        logic [7:0] d1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        do_start("reset_mid");
        send_byte(8'h05, 0, 1'b0, "reset_mid", t);
        send_byte(d0, 0, 1'b0, "reset_mid", t);
        send_byte(d1, 0, 1'b0, "reset_mid", t);
        exp_mem[0] = d0;
        exp_mem[1] = d1;
        #1 rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_mid_idle");
        make_frame(int'($urandom_range(1, DEPTH)), 1'b0);
        run_frame("after_reset", 2, -1);
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 10; f++) begin
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = int'($urandom_range(DEPTH + 1, 255));
                default: n = int'($urandom_range(1, DEPTH));
            endcase
            make_frame(n, ($urandom_range(0, 2) == 0));
            run_frame($sformatf("random%0d", f), TIMEOUT - 1, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = 8'h00;
            exp_mem[i] = 8'h00;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        start       = 1'b0;
        rst         = 1'b1;
        #2 rst = 1'b0;

        test_reset();
        test_good();
        test_bad_csum();
        test_bad_len();
        test_full_depth();
        test_timeout();
        test_timeout_len();
        test_start_mid_frame();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
